// File: rtl/y86_imem_encoder_if.sv
// Instruction-field request and byte-write bus between the program loader
// and the Y86-64 instruction memory encoder.
interface y86_imem_encoder_if;
   logic        load_pc_i;
   logic [63:0] start_pc_i;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [3:0]  icode_i;
   logic [3:0]  ifun_i;
   logic [3:0]  rA_i;
   logic [3:0]  rB_i;
   logic [63:0] valC_i;
   logic        wr_en_o;
   logic [63:0] wr_addr_o;
   logic [7:0]  wr_data_o;
   logic [63:0] pc_o;
   logic        busy_o;
   logic        done_o;
   logic        err_invalid_o;
   logic        err_bounds_o;

   modport master (
      output load_pc_i, start_pc_i, instr_valid_i, icode_i, ifun_i, rA_i, rB_i, valC_i,
      input  instr_ready_o, wr_en_o, wr_addr_o, wr_data_o, pc_o, busy_o, done_o,
             err_invalid_o, err_bounds_o
   );

   modport slave (
      input  load_pc_i, start_pc_i, instr_valid_i, icode_i, ifun_i, rA_i, rB_i, valC_i,
      output instr_ready_o, wr_en_o, wr_addr_o, wr_data_o, pc_o, busy_o, done_o,
             err_invalid_o, err_bounds_o
   );
endinterface

// File: rtl/y86_imem_encoder.sv
// Y86-64 instruction encoder: turns decoded fields into the instruction byte
// stream, writing one byte per cycle into instruction memory at the write PC.
module y86_imem_encoder #(
   parameter int IMEM_DEPTH = 1024
) (
   input logic             clk_i,
   input logic             rst_n_i,
   y86_imem_encoder_if.slave bus
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  k, k_nxt;
   logic [3:0]  len_q, in_len;
   logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
   logic [63:0] valc_q;
   logic        capture, accept, over;
   logic        wr_en_nxt, done_nxt, err_inv_nxt, err_bnd_nxt, busy_nxt;
   logic [63:0] wr_addr_nxt, pc_nxt;
   logic [7:0]  wr_data_nxt;

   // Instruction length in bytes; 0 marks an invalid icode.
   function automatic logic [3:0] len_of(input logic [3:0] icode);
      case (icode)
         4'h0, 4'h1, 4'h9:             len_of = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB:       len_of = 4'd2;
         4'h3, 4'h4, 4'h5:             len_of = 4'd10;
         4'h7, 4'h8:                   len_of = 4'd9;
         default:                      len_of = 4'd0;
      endcase
   endfunction

   // Byte k of the encoding: opcode, optional register byte, then valC LSB first.
   function automatic logic [7:0] enc_byte(input logic [3:0] icode, input logic [3:0] ifun,
                                           input logic [3:0] ra, input logic [3:0] rb,
                                           input logic [63:0] valc, input logic [3:0] idx);
      logic        has_reg;
      logic [3:0]  vidx;
      logic [63:0] sh;
      has_reg = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
      vidx    = idx - 4'd1 - {3'b000, has_reg};
      sh      = valc >> {vidx, 3'b000};
      if (idx == 4'd0)              enc_byte = {icode, ifun};
      else if (has_reg && idx == 4'd1) enc_byte = {ra, rb};
      else                          enc_byte = sh[7:0];
   endfunction

   assign in_len            = len_of(bus.icode_i);
   assign bus.instr_ready_o = rst_n_i && (state == IDLE) && !bus.err_bounds_o && !bus.load_pc_i;
   assign accept            = bus.instr_valid_i && bus.instr_ready_o;
   // 65-bit sum so a write PC near 2^64 cannot wrap past the bound.
   assign over              = ({1'b0, bus.pc_o} + {61'd0, in_len}) > 65'(IMEM_DEPTH);

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and next values of all registered outputs.
   always_comb begin
      state_nxt   = state;
      k_nxt       = k;
      capture     = 1'b0;
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = bus.wr_addr_o;
      wr_data_nxt = bus.wr_data_o;
      done_nxt    = 1'b0;
      err_inv_nxt = 1'b0;
      err_bnd_nxt = bus.err_bounds_o;
      pc_nxt      = bus.pc_o;
      if (bus.load_pc_i) begin
         state_nxt   = IDLE;
         k_nxt       = 4'd0;
         pc_nxt      = bus.start_pc_i;
         err_bnd_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               if (in_len == 4'd0) err_inv_nxt = 1'b1;
               else if (over)      err_bnd_nxt = 1'b1;
               else begin
                  capture     = 1'b1;
                  state_nxt   = WRITE;
                  k_nxt       = 4'd0;
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = bus.pc_o;
                  wr_data_nxt = enc_byte(bus.icode_i, bus.ifun_i, bus.rA_i, bus.rB_i,
                                         bus.valC_i, 4'd0);
                  done_nxt    = (in_len == 4'd1);
               end
            end
            WRITE: if (k == len_q - 4'd1) begin
               state_nxt = IDLE;
               k_nxt     = 4'd0;
               pc_nxt    = bus.pc_o + {60'd0, len_q};
            end else begin
               k_nxt       = k + 4'd1;
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = bus.pc_o + {60'd0, k} + 64'd1;
               wr_data_nxt = enc_byte(icode_q, ifun_q, ra_q, rb_q, valc_q, k + 4'd1);
               done_nxt    = (k + 4'd2 == len_q);
            end
            default: state_nxt = IDLE;
         endcase
      end
      busy_nxt = (state_nxt == WRITE);
   end

   // Output, byte-index and write-PC registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         k                 <= 4'd0;
         bus.wr_en_o       <= 1'b0;
         bus.wr_addr_o     <= 64'd0;
         bus.wr_data_o     <= 8'd0;
         bus.pc_o          <= 64'd0;
         bus.busy_o        <= 1'b0;
         bus.done_o        <= 1'b0;
         bus.err_invalid_o <= 1'b0;
         bus.err_bounds_o  <= 1'b0;
      end else begin
         k                 <= k_nxt;
         bus.wr_en_o       <= wr_en_nxt;
         bus.wr_addr_o     <= wr_addr_nxt;
         bus.wr_data_o     <= wr_data_nxt;
         bus.pc_o          <= pc_nxt;
         bus.busy_o        <= busy_nxt;
         bus.done_o        <= done_nxt;
         bus.err_invalid_o <= err_inv_nxt;
         bus.err_bounds_o  <= err_bnd_nxt;
      end
   end

   // Captured instruction fields, held for the remaining bytes.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         len_q   <= 4'd0;
         icode_q <= 4'd0;
         ifun_q  <= 4'd0;
         ra_q    <= 4'd0;
         rb_q    <= 4'd0;
         valc_q  <= 64'd0;
      end else if (capture) begin
         len_q   <= in_len;
         icode_q <= bus.icode_i;
         ifun_q  <= bus.ifun_i;
         ra_q    <= bus.rA_i;
         rb_q    <= bus.rB_i;
         valc_q  <= bus.valC_i;
      end
   end

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Directed bench for y86_imem_encoder with hand-computed byte streams.
module tb_y86_imem_encoder;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   int   errs = 0;
   int   checks = 0;
   int   done_cnt = 0;
   int   inv_cnt = 0;
   logic [63:0] log_addr[$];
   logic [7:0]  log_data[$];
   logic [7:0]  exp_b[16];

   y86_imem_encoder_if bus();

   y86_imem_encoder #(.IMEM_DEPTH(1024)) dut (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   // Record every byte write and count pulses.
   always @(negedge clk_i) begin
      if (bus.wr_en_o) begin
         log_addr.push_back(bus.wr_addr_o);
         log_data.push_back(bus.wr_data_o);
      end
      if (bus.done_o)        done_cnt++;
      if (bus.err_invalid_o) inv_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic load(input logic [63:0] v);
      @(negedge clk_i);
      bus.load_pc_i  = 1'b1;
      bus.start_pc_i = v;
      @(negedge clk_i);
      bus.load_pc_i  = 1'b0;
      #1;
      clear_log();
   endtask

   // Present fields at a negedge once ready is seen; accepted on the next posedge.
   task automatic accept(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!bus.instr_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("ready_wait", {63'd0, bus.instr_ready_o}, 64'd1);
      bus.icode_i = ic; bus.ifun_i = fn; bus.rA_i = ra; bus.rB_i = rb; bus.valC_i = vc;
      bus.instr_valid_i = 1'b1;
      @(posedge clk_i);
      #1 bus.instr_valid_i = 1'b0;
   endtask

   task automatic check_log(input string tag, input logic [63:0] base, input int n);
      chk({tag, "_cnt"}, 64'(log_data.size()), 64'(n));
      for (int i = 0; i < n; i++)
         if (i < log_data.size()) begin
            chk({tag, "_addr"}, log_addr[i], base + 64'(i));
            chk({tag, "_data"}, {56'd0, log_data[i]}, {56'd0, exp_b[i]});
         end
   endtask

   initial begin
      int d0;
      bus.load_pc_i = 0; bus.start_pc_i = 0; bus.instr_valid_i = 0;
      bus.icode_i = 0; bus.ifun_i = 0; bus.rA_i = 0; bus.rB_i = 0; bus.valC_i = 0;

      // Reset values
      #12;
      chk("rst_ready", {63'd0, bus.instr_ready_o}, 64'd0);
      chk("rst_pc", bus.pc_o, 64'd0);
      chk("rst_wr_en", {63'd0, bus.wr_en_o}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
      chk("rst_errb", {63'd0, bus.err_bounds_o}, 64'd0);
      @(negedge clk_i) rst_n_i = 1'b1;
      #1 chk("ready_after_rst", {63'd0, bus.instr_ready_o}, 64'd1);

      // 2-byte OPq, cycle by cycle
      clear_log();
      accept(4'h6, 4'h1, 4'h5, 4'h6, 64'd0);
      @(negedge clk_i);
      chk("op_b0_en", {63'd0, bus.wr_en_o}, 64'd1);
      chk("op_b0_addr", bus.wr_addr_o, 64'd0);
      chk("op_b0_data", {56'd0, bus.wr_data_o}, 64'h61);
      chk("op_b0_busy", {63'd0, bus.busy_o}, 64'd1);
      chk("op_b0_ready", {63'd0, bus.instr_ready_o}, 64'd0);
      chk("op_b0_done", {63'd0, bus.done_o}, 64'd0);
      @(negedge clk_i);
      chk("op_b1_addr", bus.wr_addr_o, 64'd1);
      chk("op_b1_data", {56'd0, bus.wr_data_o}, 64'h56);
      chk("op_b1_done", {63'd0, bus.done_o}, 64'd1);
      @(negedge clk_i);
      chk("op_ready", {63'd0, bus.instr_ready_o}, 64'd1);
      chk("op_pc", bus.pc_o, 64'd2);
      chk("op_wr_en", {63'd0, bus.wr_en_o}, 64'd0);
      chk("op_busy", {63'd0, bus.busy_o}, 64'd0);

      // 10-byte irmovq from pc 10
      load(64'd10);
      accept(4'h3, 4'h0, 4'hF, 4'h5, 64'h1122334455667788);
      repeat (11) @(negedge clk_i);
      #1;
      exp_b[0] = 8'h30; exp_b[1] = 8'hF5; exp_b[2] = 8'h88; exp_b[3] = 8'h77; exp_b[4] = 8'h66;
      exp_b[5] = 8'h55; exp_b[6] = 8'h44; exp_b[7] = 8'h33; exp_b[8] = 8'h22; exp_b[9] = 8'h11;
      check_log("irmov", 64'd10, 10);
      chk("irmov_pc", bus.pc_o, 64'd20);
      chk("irmov_ready", {63'd0, bus.instr_ready_o}, 64'd1);

      // 9-byte jmp then 1-byte nop
      clear_log();
      accept(4'h7, 4'h0, 4'h0, 4'h0, 64'h1000);
      repeat (10) @(negedge clk_i);
      #1;
      exp_b[0] = 8'h70; exp_b[1] = 8'h00; exp_b[2] = 8'h10;
      for (int i = 3; i < 9; i++) exp_b[i] = 8'h00;
      check_log("jmp", 64'd20, 9);
      chk("jmp_pc", bus.pc_o, 64'd29);
      clear_log();
      accept(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
      repeat (2) @(negedge clk_i);
      #1;
      exp_b[0] = 8'h10;
      check_log("nop", 64'd29, 1);
      chk("nop_pc", bus.pc_o, 64'd30);

      // Invalid icode: pulse only, then a normal halt
      clear_log();
      d0 = inv_cnt;
      accept(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
      repeat (4) @(negedge clk_i);
      #1;
      chk("inv_pulses", 64'(inv_cnt - d0), 64'd1);
      chk("inv_writes", 64'(log_data.size()), 64'd0);
      chk("inv_pc", bus.pc_o, 64'd30);
      accept(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
      repeat (2) @(negedge clk_i);
      #1;
      exp_b[0] = 8'h00;
      check_log("halt", 64'd30, 1);
      chk("halt_pc", bus.pc_o, 64'd31);

      // Bounds: 1020 + 10 > 1024
      load(64'd1020);
      accept(4'h3, 4'h0, 4'h1, 4'h2, 64'd0);
      repeat (2) @(negedge clk_i);
      #1;
      chk("bnd_flag", {63'd0, bus.err_bounds_o}, 64'd1);
      chk("bnd_ready", {63'd0, bus.instr_ready_o}, 64'd0);
      chk("bnd_writes", 64'(log_data.size()), 64'd0);
      chk("bnd_pc", bus.pc_o, 64'd1020);
      load(64'd0);
      chk("bnd_clr_flag", {63'd0, bus.err_bounds_o}, 64'd0);
      chk("bnd_clr_ready", {63'd0, bus.instr_ready_o}, 64'd1);
      chk("bnd_clr_pc", bus.pc_o, 64'd0);

      // Exact fit ending at 1023, then one more byte overflows
      load(64'd1014);
      accept(4'h4, 4'h0, 4'h1, 4'h2, 64'h0000_0000_0000_00AB);
      repeat (11) @(negedge clk_i);
      #1;
      exp_b[0] = 8'h40; exp_b[1] = 8'h12; exp_b[2] = 8'hAB;
      for (int i = 3; i < 10; i++) exp_b[i] = 8'h00;
      check_log("fit", 64'd1014, 10);
      chk("fit_pc", bus.pc_o, 64'd1024);
      chk("fit_flag", {63'd0, bus.err_bounds_o}, 64'd0);
      clear_log();
      accept(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
      repeat (2) @(negedge clk_i);
      #1;
      chk("ovf_flag", {63'd0, bus.err_bounds_o}, 64'd1);
      chk("ovf_writes", 64'(log_data.size()), 64'd0);

      // Abort via load_pc during the third byte
      load(64'd40);
      d0 = done_cnt;
      accept(4'h5, 4'h0, 4'h3, 4'h4, 64'h0000_0000_0000_00EE);
      repeat (3) @(negedge clk_i);
      bus.load_pc_i  = 1'b1;
      bus.start_pc_i = 64'd100;
      @(negedge clk_i);
      bus.load_pc_i  = 1'b0;
      #1;
      chk("abort_wr_en", {63'd0, bus.wr_en_o}, 64'd0);
      chk("abort_busy", {63'd0, bus.busy_o}, 64'd0);
      chk("abort_pc", bus.pc_o, 64'd100);
      chk("abort_ready", {63'd0, bus.instr_ready_o}, 64'd1);
      exp_b[0] = 8'h50; exp_b[1] = 8'h34; exp_b[2] = 8'hEE;
      check_log("abort", 64'd40, 3);
      repeat (3) @(negedge clk_i);
      chk("abort_done", 64'(done_cnt - d0), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
